// File: rtl/mips_commit_checker.sv
// In-order retirement checker: compares each core commit against the head of an expected-commit FIFO.
// Optional idle watchdog enabled by defining CHECKER_TIMEOUT_EN.
module mips_commit_checker #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     stop_on_fail,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [PC_W-1:0]          exp_pc,
    input  logic                     exp_we,
    input  logic [REG_AW-1:0]        exp_dest,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic                     commit_valid,
    input  logic [PC_W-1:0]          commit_pc,
    input  logic                     commit_we,
    input  logic [REG_AW-1:0]        commit_dest,
    input  logic [DATA_W-1:0]        commit_data,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         fail_count,
    output logic                     mismatch,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level,
    output logic [PC_W-1:0]          err_pc,
    output logic [DATA_W-1:0]        err_got,
    output logic [DATA_W-1:0]        err_exp,
    output logic                     timeout
);

    // state | meaning
    // RUN   | commits are checked, pushes accepted
    // HALT  | stopped on a failure; commits ignored, results frozen until clear

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic RUN  = 1'b0;
    localparam logic HALT = 1'b1;

    logic              state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic              mem_we   [DEPTH];
    logic [REG_AW-1:0] mem_dest [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PC_W-1:0]   head_pc;
    logic              head_we;
    logic [REG_AW-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic commit_fire;
    logic head_match;
    logic pass_evt;
    logic fail_evt;
    logic wd_fire;
    logic err_captured;

    assign head_pc   = mem_pc[rd_ptr];
    assign head_we   = mem_we[rd_ptr];
    assign head_dest = mem_dest[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    assign empty       = (level == '0);
    assign full        = (level == FULL_LEVEL);
    assign exp_ready   = !full && (state == RUN);
    assign push        = exp_valid && exp_ready && !clear;
    assign commit_fire = commit_valid && (state == RUN) && !clear;
    assign halted      = (state == HALT);

    // dest only matters for writes; writes to $0 are architecturally discarded, so skip data
    always_comb begin
        head_match = (commit_pc == head_pc) && (commit_we == head_we);
        if (head_we) begin
            if (commit_dest != head_dest) begin
                head_match = 1'b0;
            end
            if ((head_dest != '0) && (commit_data != head_data)) begin
                head_match = 1'b0;
            end
        end
    end

    assign pass_evt = commit_fire && !empty && head_match;
    assign fail_evt = (commit_fire && (empty || !head_match)) || wd_fire;
    assign pop      = (commit_fire && !empty) || wd_fire;

`ifdef CHECKER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] wd_cnt;
    logic          wd_arm;

    assign wd_arm  = (state == RUN) && !empty && !commit_valid && !clear;
    assign wd_fire = wd_arm && (wd_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt  <= WD_LOAD;
            timeout <= 1'b0;
        end else if (clear) begin
            wd_cnt  <= WD_LOAD;
            timeout <= 1'b0;
        end else if (wd_fire) begin
            wd_cnt  <= WD_LOAD;
            timeout <= 1'b1;
        end else if (wd_arm) begin
            wd_cnt  <= wd_cnt - 1'b1;
        end else begin
            wd_cnt  <= WD_LOAD;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr]   <= exp_pc;
            mem_we[wr_ptr]   <= exp_we;
            mem_dest[wr_ptr] <= exp_dest;
            mem_data[wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else if (clear) begin
            state <= RUN;
        end else if (fail_evt && stop_on_fail) begin
            state <= HALT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
            mismatch   <= 1'b0;
        end else if (clear) begin
            pass_count <= '0;
            fail_count <= '0;
            mismatch   <= 1'b0;
        end else begin
            mismatch <= fail_evt;
            if (pass_evt && (pass_count != '1)) begin
                pass_count <= pass_count + 1'b1;
            end
            if (fail_evt && (fail_count != '1)) begin
                fail_count <= fail_count + 1'b1;
            end
        end
    end

    // first failure only; a watchdog failure has no commit to record
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_captured <= 1'b0;
            err_pc       <= '0;
            err_got      <= '0;
            err_exp      <= '0;
        end else if (clear) begin
            err_captured <= 1'b0;
            err_pc       <= '0;
            err_got      <= '0;
            err_exp      <= '0;
        end else if (fail_evt && !err_captured) begin
            err_captured <= 1'b1;
            if (wd_fire) begin
                err_pc  <= '0;
                err_got <= '0;
                err_exp <= '0;
            end else begin
                err_pc  <= commit_pc;
                err_got <= commit_data;
                err_exp <= empty ? '0 : head_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_commit_checker.sv
// Directed bench for mips_commit_checker: vector table plus sequences for full/wrap, saturation,
// asynchronous reset and the optional watchdog (CHECKER_TIMEOUT_EN).
module tb_mips_commit_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear, stop_on_fail;
    logic        exp_valid, exp_ready;
    logic [31:0] exp_pc;
    logic        exp_we;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_we;
    logic [4:0]  commit_dest;
    logic [31:0] commit_data;
    logic [7:0]  pass_count, fail_count;
    logic        mismatch, halted, timeout;
    logic [4:0]  level;
    logic [31:0] err_pc, err_got, err_exp;

    int checks = 0;
    int errors = 0;

    mips_commit_checker #(
        .DATA_W(32), .PC_W(32), .REG_AW(5), .DEPTH(16), .CNT_W(8), .TIMEOUT(64)
    ) dut (
        .clock(clock), .reset(reset), .clear(clear), .stop_on_fail(stop_on_fail),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc), .exp_we(exp_we),
        .exp_dest(exp_dest), .exp_data(exp_data), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_we(commit_we), .commit_dest(commit_dest),
        .commit_data(commit_data), .pass_count(pass_count), .fail_count(fail_count),
        .mismatch(mismatch), .halted(halted), .level(level), .err_pc(err_pc),
        .err_got(err_got), .err_exp(err_exp), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        clr, sof, ev;
        logic [31:0] epc;
        logic        ewe;
        logic [4:0]  edst;
        logic [31:0] edat;
        logic        cv;
        logic [31:0] cpc;
        logic        cwe;
        logic [4:0]  cdst;
        logic [31:0] cdat;
        logic [7:0]  x_pass, x_fail;
        logic        x_mm, x_halt;
        logic [4:0]  x_lvl;
        logic        x_rdy;
        logic [31:0] x_epc, x_got, x_exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic idle();
        clear = 0; exp_valid = 0; commit_valid = 0;
        exp_pc = 0; exp_we = 0; exp_dest = 0; exp_data = 0;
        commit_pc = 0; commit_we = 0; commit_dest = 0; commit_data = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_e(input logic [31:0] pc, input logic we, input logic [4:0] d, input logic [31:0] v);
        exp_valid = 1; exp_pc = pc; exp_we = we; exp_dest = d; exp_data = v;
    endtask

    task automatic commit_e(input logic [31:0] pc, input logic we, input logic [4:0] d, input logic [31:0] v);
        commit_valid = 1; commit_pc = pc; commit_we = we; commit_dest = d; commit_data = v;
    endtask

    task automatic do_clear();
        idle(); clear = 1; step(); clear = 0;
    endtask

    function automatic vec_t mk(
        input logic clr, sof, ev, input logic [31:0] epc, input logic ewe, input logic [4:0] edst,
        input logic [31:0] edat, input logic cv, input logic [31:0] cpc, input logic cwe,
        input logic [4:0] cdst, input logic [31:0] cdat, input logic [7:0] xp, xf,
        input logic xm, xh, input logic [4:0] xl, input logic xr,
        input logic [31:0] xepc, xgot, xexp);
        vec_t v;
        v = '{clr, sof, ev, epc, ewe, edst, edat, cv, cpc, cwe, cdst, cdat,
              xp, xf, xm, xh, xl, xr, xepc, xgot, xexp};
        return v;
    endfunction

    function automatic logic [31:0] wpc(input int i);
        return 32'h100 + 32'(i) * 4;
    endfunction
    function automatic logic [4:0] wdst(input int i);
        return 5'((i % 31) + 1);
    endfunction
    function automatic logic [31:0] wdat(input int i);
        return 32'(i) * 3 + 1;
    endfunction

    initial begin
        int p, c, mlvl;
        //            clr sof ev epc      we dst edat     cv cpc      we dst cdat   | pass fail mm halt lvl rdy err_pc err_got err_exp
        vt[0]  = mk(0, 0, 1, 32'h00, 1, 1, 32'h05, 0, 0,       0, 0, 0,      0, 0, 0, 0, 1, 1, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h00, 1, 1, 32'h05, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        vt[2]  = mk(0, 1, 1, 32'h04, 1, 2, 32'h0A, 0, 0,       0, 0, 0,      1, 0, 0, 0, 1, 1, 0, 0, 0);
        vt[3]  = mk(0, 1, 0, 0,      0, 0, 0,      1, 32'h04, 1, 2, 32'h0B, 1, 1, 1, 1, 0, 0, 32'h04, 32'h0B, 32'h0A);
        vt[4]  = mk(0, 1, 1, 32'h40, 1, 1, 32'h01, 1, 32'h04, 1, 2, 32'h0A, 1, 1, 0, 1, 0, 0, 32'h04, 32'h0B, 32'h0A);
        vt[5]  = mk(1, 1, 0, 0,      0, 0, 0,      1, 32'h04, 1, 2, 32'h0A, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vt[6]  = mk(0, 0, 1, 32'h08, 1, 3, 32'h33, 1, 32'h08, 1, 3, 32'h77, 0, 1, 1, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[7]  = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h08, 1, 3, 32'h33, 1, 1, 0, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[8]  = mk(0, 0, 1, 32'h0C, 1, 0, 32'h05, 0, 0,       0, 0, 0,      1, 1, 0, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[9]  = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h0C, 1, 0, 32'h00, 2, 1, 0, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[10] = mk(0, 0, 1, 32'h10, 0, 0, 32'h00, 0, 0,       0, 0, 0,      2, 1, 0, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[11] = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h10, 1, 0, 32'h00, 2, 2, 1, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[12] = mk(0, 0, 1, 32'h14, 1, 4, 32'h09, 0, 0,       0, 0, 0,      2, 2, 0, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[13] = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h14, 1, 5, 32'h09, 2, 3, 1, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[14] = mk(0, 0, 1, 32'h18, 0, 7, 32'h01, 0, 0,       0, 0, 0,      2, 3, 0, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[15] = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h18, 0, 3, 32'h02, 3, 3, 0, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[16] = mk(0, 0, 1, 32'h1C, 1, 1, 32'h01, 0, 0,       0, 0, 0,      3, 3, 0, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[17] = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h20, 1, 1, 32'h01, 3, 4, 1, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[18] = mk(0, 0, 1, 32'h24, 1, 6, 32'h10, 0, 0,       0, 0, 0,      3, 4, 0, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[19] = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h24, 1, 6, 32'h11, 3, 5, 1, 0, 0, 1, 32'h08, 32'h77, 0);
        vt[20] = mk(0, 0, 1, 32'h28, 1, 2, 32'hAA, 1, 32'h28, 1, 2, 32'hAA, 3, 6, 1, 0, 1, 1, 32'h08, 32'h77, 0);
        vt[21] = mk(0, 0, 0, 0,      0, 0, 0,      1, 32'h28, 1, 2, 32'hAA, 4, 6, 0, 0, 0, 1, 32'h08, 32'h77, 0);

        reset = 1; stop_on_fail = 0;
        idle();
        #12;
        chk("rst_pass", 32'(pass_count), 0);
        chk("rst_fail", 32'(fail_count), 0);
        chk("rst_mm", 32'(mismatch), 0);
        chk("rst_halt", 32'(halted), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(exp_ready), 1);
        chk("rst_errpc", err_pc, 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(posedge clock); #1 reset = 0;

        for (int i = 0; i < NV; i++) begin
            clear = vt[i].clr; stop_on_fail = vt[i].sof;
            exp_valid = vt[i].ev; exp_pc = vt[i].epc; exp_we = vt[i].ewe;
            exp_dest = vt[i].edst; exp_data = vt[i].edat;
            commit_valid = vt[i].cv; commit_pc = vt[i].cpc; commit_we = vt[i].cwe;
            commit_dest = vt[i].cdst; commit_data = vt[i].cdat;
            step();
            chk($sformatf("v%0d_pass", i), 32'(pass_count), 32'(vt[i].x_pass));
            chk($sformatf("v%0d_fail", i), 32'(fail_count), 32'(vt[i].x_fail));
            chk($sformatf("v%0d_mm", i), 32'(mismatch), 32'(vt[i].x_mm));
            chk($sformatf("v%0d_halt", i), 32'(halted), 32'(vt[i].x_halt));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].x_lvl));
            chk($sformatf("v%0d_ready", i), 32'(exp_ready), 32'(vt[i].x_rdy));
            chk($sformatf("v%0d_errpc", i), err_pc, vt[i].x_epc);
            chk($sformatf("v%0d_errgot", i), err_got, vt[i].x_got);
            chk($sformatf("v%0d_errexp", i), err_exp, vt[i].x_exp);
        end
        idle(); stop_on_fail = 0;

        // asynchronous reset between edges
        push_e(32'h50, 1, 1, 1); step();
        push_e(32'h54, 1, 1, 2); step();
        idle();
        chk("pre_areset_level", 32'(level), 2);
        #2 reset = 1;
        #1;
        chk("areset_level", 32'(level), 0);
        chk("areset_pass", 32'(pass_count), 0);
        chk("areset_fail", 32'(fail_count), 0);
        chk("areset_ready", 32'(exp_ready), 1);
        @(posedge clock); #1 reset = 0;

        // watchdog
        do_clear();
        push_e(32'h60, 1, 1, 1); step(); idle();
`ifdef CHECKER_TIMEOUT_EN
        for (int i = 0; i < 63; i++) step();
        chk("wd_before_timeout", 32'(timeout), 0);
        chk("wd_before_level", 32'(level), 1);
        step();
        chk("wd_timeout", 32'(timeout), 1);
        chk("wd_fail", 32'(fail_count), 1);
        chk("wd_mm", 32'(mismatch), 1);
        chk("wd_level", 32'(level), 0);
        chk("wd_errpc", err_pc, 0);
        chk("wd_errexp", err_exp, 0);
        step();
        chk("wd_sticky", 32'(timeout), 1);
`else
        for (int i = 0; i < 70; i++) step();
        chk("nowd_timeout", 32'(timeout), 0);
        chk("nowd_level", 32'(level), 1);
        chk("nowd_fail", 32'(fail_count), 0);
`endif

        // fill to full, refused push, then wrap pointers over 40 matched commits
        do_clear();
        for (int i = 0; i < 16; i++) begin
            push_e(wpc(i), 1, wdst(i), wdat(i)); step();
        end
        idle();
        chk("full_level", 32'(level), 16);
        chk("full_ready", 32'(exp_ready), 0);
        push_e(32'hDEAD, 1, 9, 32'hBAD); step(); idle();
        chk("full_refused_level", 32'(level), 16);
        p = 16; mlvl = 16;
        for (c = 0; c < 40; c++) begin
            idle();
            commit_e(wpc(c), 1, wdst(c), wdat(c));
            if (p < 40 && mlvl < 16) begin
                push_e(wpc(p), 1, wdst(p), wdat(p));
                p++;
            end else begin
                mlvl--;
            end
            step();
            chk($sformatf("wrap%0d_level", c), 32'(level), 32'(mlvl));
        end
        idle();
        chk("wrap_pass", 32'(pass_count), 40);
        chk("wrap_fail", 32'(fail_count), 0);

        // saturation of fail_count via repeated underflow
        do_clear();
        commit_e(32'h80, 1, 1, 1);
        for (int i = 0; i < 256; i++) step();
        idle();
        chk("sat_fail", 32'(fail_count), 255);
        chk("sat_mm", 32'(mismatch), 1);
        chk("sat_pass", 32'(pass_count), 0);
        chk("sat_level", 32'(level), 0);
        chk("sat_errpc", err_pc, 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
